bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial stage that sits directly upstream of the bit-indexed register-assembly stage. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per enabled clock, with start-of-word and end-of-word markers. Back-to-back words stream with no idle cycle between them, so the downstream index counter sees a contiguous bit stream.

## Interface
- WIDTH, default 8: word width in bits; legal range ≥ 2.
- LSB_FIRST, default 1: 1 = bit 0 emitted first; 0 = bit WIDTH-1 emitted first.

- i_clk  input  1  the only clock; all state updates on its rising edge.
- i_rst_n  input  1  reset, synchronous and active-low.
- i_valid  input  1  upstream word valid.
- i_data  input  WIDTH  upstream word.
- o_ready  output  1  the block accepts i_data this cycle.
- i_en  input  1  downstream advance enable; 0 freezes the shifter.
- o_bit  output  1  current serial bit.
- o_bit_valid  output  1  o_bit carries a real bit this cycle.
- o_sof  output  1  o_bit is the first bit of a word.
- o_eof  output  1  o_bit is the last bit of a word.

## Operation
- Storage:
  - hold_q[WIDTH-1:0] with hold_v.
  - shift_q[WIDTH-1:0] with busy.
  - bit counter cnt, width $clog2(WIDTH).
- States:
  - IDLE (busy=0).
  - SHIFT (busy=1).
- Handshake:
  - o_ready = ~hold_v. This is combinational from registered state only, with no path from i_valid.
  - Accept on i_valid && o_ready: hold_q <= i_data, hold_v <= 1.
  - i_data is ignored when no accept occurs.
- IDLE → SHIFT:
  - Condition: hold_v=1.
  - Actions: shift_q <= hold_q, cnt <= 0, hold_v <= 0 (unless a new word is accepted on the same edge).
  - This transfer does not depend on i_en.
- In SHIFT:
  - o_bit = shift_q[0] if LSB_FIRST, else shift_q[WIDTH-1].
  - o_bit_valid = i_en.
  - o_sof = i_en && cnt==0.
  - o_eof = i_en && cnt==WIDTH-1.
- Advance in SHIFT with i_en=1:
  - shift_q shifts toward the output end, zero-filled.
  - cnt increments.
- Last bit (cnt==WIDTH-1, i_en=1):
  - If hold_v=1: reload shift_q from hold_q, cnt <= 0, stay in SHIFT, clear hold_v. The gapless path.
  - Else: go to IDLE.
- SHIFT with i_en=0: shift_q and cnt hold; o_bit_valid, o_sof and o_eof are all 0. Holding-register acceptance continues normally.
- Simultaneous events:
  - If hold_v is cleared by a transfer on the same edge that a new word is accepted, the new word wins and hold_v stays 1.
  - o_ready in that cycle was 0, so this case arises only when hold_v was already 0. The rule is stated for completeness of the next-state equation.
- In IDLE, o_bit=0 and all markers are 0.

## Timing
- Reset, while i_rst_n=0 at an edge:
  - hold_v=0, busy=0, cnt=0, shift_q=0, hold_q=0.
  - Outputs after that edge: o_ready=1, o_bit=0, o_bit_valid=0, o_sof=0, o_eof=0.
- Reset mid-word: the partial word and any held word are discarded; no eof is emitted.
- Latency, with i_en held at 1:
  - Word accepted at edge N.
  - Moved to the shifter at edge N+1.
  - First bit (o_sof) is visible in the cycle after N+1.
  - Last bit (o_eof) is visible WIDTH-1 cycles later.
- Throughput: sustained one word per WIDTH enabled cycles, with no bubble, provided upstream refills hold within WIDTH-1 cycles.
- o_ready deasserts in the cycle after an accept. It reasserts in the cycle after the hold→shifter transfer.
- i_en affects outputs combinationally in the same cycle; it has no effect on o_ready.

## Test plan
- Reset, then i_valid=1 with i_data=8'hA5, i_en=1, LSB_FIRST=1:
  - o_bit = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 2 cycles after the accept.
  - o_sof on the first bit only; o_eof on the eighth bit only.
- Same stimulus with LSB_FIRST=0: o_bit = 1,0,1,0,0,1,0,1 (MSB first, since A5 is a palindrome), then repeat with 8'h01 → 0,0,0,0,0,0,0,1.
- Back-to-back 8'hFF then 8'h00 with i_valid held high:
  - 16 contiguous valid bits (eight 1s, then eight 0s) with no gap.
  - o_eof on cycle 8, o_sof on cycle 9.
  - o_ready low from the cycle after the second accept until the second word transfers.
- i_en toggled 1,0,0,1,... during 8'hC3:
  - The bit sequence is unchanged and delivered only on i_en=1 cycles.
  - o_bit_valid=0 on frozen cycles; the eof cycle is the 8th enabled cycle.
- i_rst_n=0 asserted after 3 bits of 8'hF0, with a second word held:
  - On the next edge all outputs read reset values and o_ready=1.
  - A new word 8'h5A afterwards serializes correctly from bit 0.
- i_valid=1 while o_ready=0 with changing i_data: no word is accepted or corrupted; only the held word is emitted.

Source files
------------

// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Bundles the word-input handshake and the serial-output stream of
//   bit_serializer. The clock and reset stay outside as plain ports.
//
//   Handshake: a word moves from upstream into the block on a rising edge
//   where i_valid && o_ready. o_ready depends only on registered state, never
//   on i_valid, and i_data is don't-care on any cycle without that product.
//
//   Signals
//     i_valid     upstream word valid
//     i_data      upstream word (WIDTH bits)
//     o_ready     block can take i_data this cycle
//     i_en        downstream advance enable (0 freezes the shifter)
//     o_bit       current serial bit
//     o_bit_valid o_bit is a real bit this cycle
//     o_sof       o_bit is the first bit of a word
//     o_eof       o_bit is the last bit of a word
//
//   Modports
//     master : the side feeding words and consuming bits (testbench/upstream)
//     slave  : the serializer itself
interface bit_serializer_if #(
   parameter int WIDTH = 8
) ();

   logic             i_valid;
   logic [WIDTH-1:0] i_data;
   logic             o_ready;
   logic             i_en;
   logic             o_bit;
   logic             o_bit_valid;
   logic             o_sof;
   logic             o_eof;

   modport master (
      output i_valid, i_data, i_en,
      input  o_ready, o_bit, o_bit_valid, o_sof, o_eof
   );

   modport slave (
      input  i_valid, i_data, i_en,
      output o_ready, o_bit, o_bit_valid, o_sof, o_eof
   );

endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial stage. Accepts WIDTH-bit words into a one-word holding
//   register and shifts them out one bit per enabled clock with start/end of
//   word markers. A word waiting in the holding register is loaded on the
//   same edge that the last bit of the current word leaves, so consecutive
//   words form a contiguous bit stream.
//
//   Parameters
//     WIDTH     word width in bits (>= 2)
//     LSB_FIRST 1: bit 0 emitted first; 0: bit WIDTH-1 emitted first
//
//   Ports
//     i_clk    clock, all state updates on the rising edge
//     i_rst_n  synchronous active-low reset
//     bus      bit_serializer_if slave modport (handshake + serial stream)
//     o_state  FSM state for observation (0 = IDLE, 1 = SHIFT)
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   bit_serializer_if.slave  bus,
   output logic             o_state
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_v_q, hold_v_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               accept;
   logic               head_bit;
   logic [WIDTH-1:0]   shift_adv;

   // Ready comes from the holding flag alone, so there is no combinational
   // path from i_valid back to o_ready.
   assign bus.o_ready = ~hold_v_q;
   assign accept      = bus.i_valid & ~hold_v_q;
   assign o_state     = (state_q == SHIFT);

   // Output end of the shifter and the register advanced toward it.
   always_comb begin
      if (LSB_FIRST) begin
         head_bit  = shift_q[0];
         shift_adv = {1'b0, shift_q[WIDTH-1:1]};
      end else begin
         head_bit  = shift_q[WIDTH-1];
         shift_adv = {shift_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d         = state_q;
      hold_d          = hold_q;
      hold_v_d        = hold_v_q;
      shift_d         = shift_q;
      cnt_d           = cnt_q;
      bus.o_bit       = 1'b0;
      bus.o_bit_valid = 1'b0;
      bus.o_sof       = 1'b0;
      bus.o_eof       = 1'b0;

      case (state_q)
         IDLE: begin
            // Loading the shifter is not gated by i_en.
            if (hold_v_q) begin
               shift_d  = hold_q;
               cnt_d    = '0;
               hold_v_d = 1'b0;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            bus.o_bit       = head_bit;
            bus.o_bit_valid = bus.i_en;
            bus.o_sof       = bus.i_en && (cnt_q == '0);
            bus.o_eof       = bus.i_en && (cnt_q == CNT_LAST);

            if (bus.i_en) begin
               if (cnt_q == CNT_LAST) begin
                  if (hold_v_q) begin
                     // Gapless handoff: next word starts on the following cycle.
                     shift_d  = hold_q;
                     cnt_d    = '0;
                     hold_v_d = 1'b0;
                  end else begin
                     shift_d = shift_adv;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  shift_d = shift_adv;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // Applied last so a same-edge accept wins over a transfer clearing
      // hold_v (only reachable when hold_v was already 0).
      if (accept) begin
         hold_d   = bus.i_data;
         hold_v_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         hold_q   <= '0;
         hold_v_q <= 1'b0;
         shift_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Drives one LSB-first and one MSB-first bit_serializer (WIDTH=8) with the
//   same stimulus and compares {o_ready, o_bit, o_bit_valid, o_sof, o_eof} of
//   each against hand-computed expectations every sampled cycle.
module tb_bit_serializer;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   logic       tb_valid = 1'b0;
   logic [7:0] tb_data  = 8'h00;
   logic       tb_en    = 1'b0;
   logic       state_l, state_m;

   bit_serializer_if #(.WIDTH(8)) bus_l ();
   bit_serializer_if #(.WIDTH(8)) bus_m ();

   assign bus_l.i_valid = tb_valid;
   assign bus_l.i_data  = tb_data;
   assign bus_l.i_en    = tb_en;
   assign bus_m.i_valid = tb_valid;
   assign bus_m.i_data  = tb_data;
   assign bus_m.i_en    = tb_en;

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus_l),
      .o_state (state_l)
   );

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus_m),
      .o_state (state_m)
   );

   logic [4:0] act_l, act_m;
   assign act_l = {bus_l.o_ready, bus_l.o_bit, bus_l.o_bit_valid, bus_l.o_sof, bus_l.o_eof};
   assign act_m = {bus_m.o_ready, bus_m.o_bit, bus_m.o_bit_valid, bus_m.o_sof, bus_m.o_eof};

   localparam logic [4:0] IDLE_RDY = 5'b1_0_0_0_0;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- scoreboard ----------------
   logic [0:0] exp_lsb_q[$];
   logic [0:0] exp_msb_q[$];

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {rdy,bit,vld,sof,eof}=%b want %b", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic sample(input string name, input logic [4:0] exp_l, input logic [4:0] exp_m);
      @(negedge i_clk);
      check({name, "/lsb"}, act_l, exp_l);
      check({name, "/msb"}, act_m, exp_m);
   endtask

   // Send one isolated word and follow it through. seq_* bit k is the k-th
   // emitted bit; en_pat bit (c-1)%8 is i_en in cycle c after the transfer.
   task automatic run_word(input string name, input logic [7:0] data,
                           input logic [7:0] seq_lsb, input logic [7:0] seq_msb,
                           input logic [7:0] en_pat);
      int k;
      int c;
      logic bl, bm;
      for (int i = 0; i < 8; i++) begin
         exp_lsb_q.push_back(seq_lsb[i]);
         exp_msb_q.push_back(seq_msb[i]);
      end
      cycle();
      tb_valid = 1'b1;
      tb_data  = data;
      tb_en    = 1'b0;
      sample({name, ":pre"}, IDLE_RDY, IDLE_RDY);
      cycle();                          // accept edge
      tb_valid = 1'b0;
      tb_data  = 8'($urandom_range(0, 255));
      tb_en    = 1'($urandom_range(0, 1));
      sample({name, ":held"}, 5'b0_0_0_0_0, 5'b0_0_0_0_0);
      k = 0;
      c = 1;
      while (k < 8 && c < 40) begin
         cycle();
         tb_en   = en_pat[(c - 1) % 8];
         tb_data = 8'($urandom_range(0, 255));
         bl = exp_lsb_q[0];
         bm = exp_msb_q[0];
         sample($sformatf("%s:c%0d", name, c),
                {1'b1, bl, tb_en, tb_en && (k == 0), tb_en && (k == 7)},
                {1'b1, bm, tb_en, tb_en && (k == 0), tb_en && (k == 7)});
         if (tb_en) begin
            void'(exp_lsb_q.pop_front());
            void'(exp_msb_q.pop_front());
            k++;
         end
         c++;
      end
      if (k < 8) begin
         n_vec++;
         n_err++;
         $display("FAIL %s:timeout got %0d bits want 8", name, k);
         exp_lsb_q.delete();
         exp_msb_q.delete();
      end
      cycle();
      tb_en = 1'b1;
      sample({name, ":post"}, IDLE_RDY, IDLE_RDY);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string      name;
      logic [7:0] data;
      logic [7:0] seq_lsb;
      logic [7:0] seq_msb;
      logic [7:0] en_pat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"a5",        8'hA5, 8'hA5, 8'hA5, 8'hFF};
      vecs[1] = '{"01",        8'h01, 8'h01, 8'h80, 8'hFF};
      vecs[2] = '{"c3_en1001", 8'hC3, 8'hC3, 8'hC3, 8'h99};
      vecs[3] = '{"96",        8'h96, 8'h96, 8'h69, 8'hFF};
      vecs[4] = '{"12_en1010", 8'h12, 8'h12, 8'h48, 8'h55};
      vecs[5] = '{"3c_enb7",   8'h3C, 8'h3C, 8'h3C, 8'hB7};

      // Reset values, with i_en high to show markers stay low.
      i_rst_n = 1'b0;
      tb_en   = 1'b1;
      repeat (3) cycle();
      sample("reset", IDLE_RDY, IDLE_RDY);
      cycle();
      i_rst_n = 1'b1;
      sample("reset_rel", IDLE_RDY, IDLE_RDY);

      for (int v = 0; v < 6; v++)
         run_word(vecs[v].name, vecs[v].data, vecs[v].seq_lsb, vecs[v].seq_msb, vecs[v].en_pat);

      // Back-to-back FF then 00 with i_valid held high; junk data while
      // o_ready=0 must never be taken.
      cycle();
      tb_valid = 1'b1;
      tb_data  = 8'hFF;
      tb_en    = 1'b1;
      sample("b2b:pre", IDLE_RDY, IDLE_RDY);
      for (int c = 0; c < 18; c++) begin
         logic [4:0] e;
         cycle();
         if (c == 0) tb_data = 8'h77;
         if (c == 1) tb_data = 8'h00;
         if (c >= 2 && c <= 8) tb_data = 8'($urandom_range(1, 255));
         if (c >= 9) tb_valid = 1'b0;
         e[4] = (c == 1) || (c >= 9);
         e[3] = (c >= 1) && (c <= 8);
         e[2] = (c >= 1) && (c <= 16);
         e[1] = (c == 1) || (c == 9);
         e[0] = (c == 8) || (c == 16);
         sample($sformatf("b2b:c%0d", c), e, e);
      end

      // Reset after three bits of F0 while 81 sits in the holding register.
      cycle();
      tb_valid = 1'b1;
      tb_data  = 8'hF0;
      tb_en    = 1'b1;
      sample("rst_mid:pre", IDLE_RDY, IDLE_RDY);
      cycle();
      tb_data = 8'h81;
      sample("rst_mid:held", 5'b0_0_0_0_0, 5'b0_0_0_0_0);
      cycle();
      sample("rst_mid:b0", 5'b1_0_1_1_0, 5'b1_1_1_1_0);
      cycle();
      tb_valid = 1'b0;
      sample("rst_mid:b1", 5'b0_0_1_0_0, 5'b0_1_1_0_0);
      cycle();
      sample("rst_mid:b2", 5'b0_0_1_0_0, 5'b0_1_1_0_0);
      i_rst_n = 1'b0;
      cycle();
      i_rst_n = 1'b1;
      sample("rst_mid:after", IDLE_RDY, IDLE_RDY);
      for (int i = 0; i < 10; i++) begin
         cycle();
         sample($sformatf("rst_mid:quiet%0d", i), IDLE_RDY, IDLE_RDY);
      end
      run_word("5a_after_rst", 8'h5A, 8'h5A, 8'h5A, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
